// File: rtl/regfile_scoreboard.sv
// Architectural register file with bypassed read ports and a
// per-register in-flight write scoreboard for RAW stall generation.
module regfile_scoreboard #(
  parameter int size         = 32,
  parameter int max_inflight = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      RD_WB,
  input  logic            WE_WB,
  input  logic [size-1:0] Final_Result,
  input  logic [4:0]      RS1_addr_i,
  input  logic [4:0]      RS2_addr_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  output logic [size-1:0] RS1_data_o,
  output logic [size-1:0] RS2_data_o,
  output logic            RS1_busy_o,
  output logic            RS2_busy_o,
  input  logic            issue_valid_i,
  input  logic            issue_we_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            kill_valid_i,
  input  logic [4:0]      kill_rd_i,
  output logic            stall_o,
  output logic            overflow_err_o,
  output logic            underflow_err_o
);

  localparam int CW = $clog2(max_inflight + 1);
  localparam int NW = CW + 2;
  localparam logic [NW-1:0] MAXN = NW'(max_inflight);
  localparam logic [CW-1:0] MAXC = CW'(max_inflight);

  logic [size-1:0] regs    [32];
  logic [CW-1:0]   cnt     [32];
  logic [CW-1:0]   cnt_nxt [32];
  logic [NW-1:0]   net     [32];
  logic            inc     [32];
  logic            ret     [32];
  logic            kil     [32];

  logic            ovf_set;
  logic            udf_set;
  logic            ovf_q;
  logic            udf_q;
  logic            ret1;
  logic            ret2;
  logic [NW-1:0]   b1;
  logic [NW-1:0]   b2;
  logic            iss_hit;
  logic            sat_stall;

  // Net counter update; the sign bit of net flags underflow.
  always_comb begin
    ovf_set = 1'b0;
    udf_set = 1'b0;
    for (int r = 0; r < 32; r++) begin
      inc[r]     = 1'b0;
      ret[r]     = 1'b0;
      kil[r]     = 1'b0;
      net[r]     = '0;
      cnt_nxt[r] = '0;
    end
    for (int r = 1; r < 32; r++) begin
      inc[r] = issue_valid_i & issue_we_i
             & (issue_rd_i == 5'(r));
      ret[r] = WE_WB & (RD_WB == 5'(r));
      kil[r] = kill_valid_i & (kill_rd_i == 5'(r));
      net[r] = NW'(cnt[r]) + NW'(inc[r])
             - NW'(ret[r]) - NW'(kil[r]);
      if (net[r][NW-1]) begin
        cnt_nxt[r] = '0;
        udf_set    = 1'b1;
      end else if (net[r] > MAXN) begin
        cnt_nxt[r] = MAXC;
        ovf_set    = 1'b1;
      end else begin
        cnt_nxt[r] = net[r][CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WE_WB && RD_WB != 5'd0) begin
        regs[RD_WB] <= Final_Result;
      end
      for (int r = 1; r < 32; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      ovf_q <= ovf_q | ovf_set;
      udf_q <= udf_q | udf_set;
    end
  end

  always_comb begin
    ret1 = WE_WB & (RD_WB == RS1_addr_i);
    ret2 = WE_WB & (RD_WB == RS2_addr_i);
    RS1_data_o = '0;
    RS2_data_o = '0;
    if (RS1_addr_i != 5'd0) begin
      RS1_data_o = ret1 ? Final_Result : regs[RS1_addr_i];
    end
    if (RS2_addr_i != 5'd0) begin
      RS2_data_o = ret2 ? Final_Result : regs[RS2_addr_i];
    end
  end

  // A same-cycle retire clears busy since the bypass carries the data.
  always_comb begin
    b1 = NW'(cnt[RS1_addr_i]) - NW'(ret1);
    b2 = NW'(cnt[RS2_addr_i]) - NW'(ret2);
    RS1_busy_o = (RS1_addr_i != 5'd0) && (b1 != '0);
    RS2_busy_o = (RS2_addr_i != 5'd0) && (b2 != '0);
  end

  always_comb begin
    iss_hit = (WE_WB & (RD_WB == issue_rd_i))
            | (kill_valid_i & (kill_rd_i == issue_rd_i));
    sat_stall = issue_we_i
              & (issue_rd_i != 5'd0)
              & (cnt[issue_rd_i] == MAXC)
              & ~iss_hit;
    stall_o = (RS1_busy_o & rs1_used_i)
            | (RS2_busy_o & rs2_used_i)
            | sat_stall;
  end

  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = udf_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random
// traffic against an array/arithmetic reference model.
module tb_regfile_scoreboard;

  localparam int MAXI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_wb;
  logic        we_wb;
  logic [31:0] fin;
  logic [4:0]  a1, a2;
  logic        u1, u2;
  logic [31:0] d1, d2;
  logic        bz1, bz2;
  logic        iv, iwe;
  logic [4:0]  ird;
  logic        kv;
  logic [4:0]  krd;
  logic        stall, ovf, udf;

  int pass_cnt = 0;
  int total    = 0;

  int          mcnt [32];
  logic [31:0] mreg [32];
  bit          movf, mudf;

  regfile_scoreboard #(.size(32), .max_inflight(MAXI)) dut (
    .clk(clk), .reset(reset),
    .RD_WB(rd_wb), .WE_WB(we_wb), .Final_Result(fin),
    .RS1_addr_i(a1), .RS2_addr_i(a2),
    .rs1_used_i(u1), .rs2_used_i(u2),
    .RS1_data_o(d1), .RS2_data_o(d2),
    .RS1_busy_o(bz1), .RS2_busy_o(bz2),
    .issue_valid_i(iv), .issue_we_i(iwe), .issue_rd_i(ird),
    .kill_valid_i(kv), .kill_rd_i(krd),
    .stall_o(stall),
    .overflow_err_o(ovf), .underflow_err_o(udf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_data(logic [4:0] a);
    if (a == 0) return 32'd0;
    if (we_wb && rd_wb == a) return fin;
    return mreg[a];
  endfunction

  function automatic logic m_busy(logic [4:0] a);
    int pend;
    if (a == 0) return 1'b0;
    pend = mcnt[a] - ((we_wb && rd_wb == a) ? 1 : 0);
    return pend != 0;
  endfunction

  function automatic logic m_stall();
    logic sat;
    sat = iwe && ird != 0 && mcnt[ird] == MAXI
       && !(we_wb && rd_wb == ird) && !(kv && krd == ird);
    return (m_busy(a1) && u1) || (m_busy(a2) && u2) || sat;
  endfunction

  task automatic idle();
    reset = 1'b1; rd_wb = '0; we_wb = 1'b0; fin = '0;
    a1 = '0; a2 = '0; u1 = 1'b0; u2 = 1'b0;
    iv = 1'b0; iwe = 1'b0; ird = '0; kv = 1'b0; krd = '0;
  endtask

  // Advance one edge, updating the model with the inputs it sees.
  task automatic tick();
    int n;
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        mcnt[r] = 0; mreg[r] = '0;
      end
      movf = 0; mudf = 0;
    end else begin
      if (we_wb && rd_wb != 0) mreg[rd_wb] = fin;
      for (int r = 1; r < 32; r++) begin
        n = mcnt[r];
        if (iv && iwe && ird == r) n++;
        if (we_wb && rd_wb == r) n--;
        if (kv && krd == r) n--;
        if (n > MAXI) begin n = MAXI; movf = 1; end
        if (n < 0) begin n = 0; mudf = 1; end
        mcnt[r] = n;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [4:0] r);
    idle(); iv = 1; iwe = 1; ird = r; tick();
  endtask

  task automatic test_reset();
    idle(); reset = 1'b0; tick(); idle();
    for (int a = 0; a < 32; a += 7) begin
      a1 = 5'(a); a2 = 5'(a + 3); u1 = 1; u2 = 1; #1;
      total++;
      if (d1 !== 32'd0 || d2 !== 32'd0) $display("FAIL reset_data a=%0d got %h/%h want 0", a, d1, d2);
      else pass_cnt++;
      total++;
      if (bz1 !== 1'b0 || bz2 !== 1'b0 || stall !== 1'b0) $display("FAIL reset_busy got %b%b%b want 000", bz1, bz2, stall);
      else pass_cnt++;
    end
    total++;
    if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL reset_err got %b%b want 00", ovf, udf);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    idle(); we_wb = 1; rd_wb = 5; fin = 32'hDEADBEEF; tick();
    idle(); a1 = 5; #1;
    total++;
    if (d1 !== 32'hDEADBEEF) $display("FAIL wr_x5 got %h want deadbeef", d1);
    else pass_cnt++;
    idle(); we_wb = 1; rd_wb = 0; fin = 32'h1234; a1 = 0; u1 = 1; #1;
    total++;
    if (d1 !== 32'd0 || bz1 !== 1'b0) $display("FAIL x0_bypass got %h busy %b want 0/0", d1, bz1);
    else pass_cnt++;
    tick(); idle(); a1 = 0; u1 = 1; #1;
    total++;
    if (d1 !== 32'd0 || bz1 !== 1'b0 || stall !== 1'b0) $display("FAIL x0_read got %h busy %b stall %b want 0", d1, bz1, stall);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle(); we_wb = 1; rd_wb = 7; fin = 32'hA5A5A5A5; a2 = 7; #1;
    total++;
    if (d2 !== 32'hA5A5A5A5) $display("FAIL bypass got %h want a5a5a5a5", d2);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_raw_stall();
    issue(3);
    for (int c = 0; c < 3; c++) begin
      idle(); a1 = 3; u1 = 1; #1;
      total++;
      if (stall !== 1'b1 || bz1 !== 1'b1) $display("FAIL raw_stall c=%0d got %b/%b want 1/1", c, stall, bz1);
      else pass_cnt++;
      tick();
    end
    idle(); a1 = 3; u1 = 1; we_wb = 1; rd_wb = 3; fin = 32'h0BADF00D; #1;
    total++;
    if (bz1 !== 1'b0 || stall !== 1'b0 || d1 !== 32'h0BADF00D) $display("FAIL raw_wb got busy %b stall %b data %h want 0 0 0badf00d", bz1, stall, d1);
    else pass_cnt++;
    tick();
    issue(3);
    idle(); a1 = 3; u1 = 0; #1;
    total++;
    if (bz1 !== 1'b1 || stall !== 1'b0) $display("FAIL raw_unused got busy %b stall %b want 1 0", bz1, stall);
    else pass_cnt++;
    we_wb = 1; rd_wb = 3; fin = 32'h3; tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) issue(9);
    idle(); iwe = 1; ird = 9; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL sat_stall got %b want 1", stall);
    else pass_cnt++;
    iv = 1; tick();
    idle(); #1;
    total++;
    if (ovf !== 1'b1) $display("FAIL sat_ovf got %b want 1", ovf);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      idle(); a1 = 9; we_wb = 1; rd_wb = 9; fin = 32'(k); #1;
      total++;
      if (bz1 !== (k != 2)) $display("FAIL sat_drain k=%0d got %b want %b", k, bz1, k != 2);
      else pass_cnt++;
      tick();
    end
    idle(); a1 = 9; #1;
    total++;
    if (bz1 !== 1'b0) $display("FAIL sat_clear got %b want 0", bz1);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    issue(4); issue(4);
    idle(); iv = 1; iwe = 1; ird = 4; we_wb = 1; rd_wb = 4; tick();
    idle(); a1 = 4; we_wb = 1; rd_wb = 4; #1;
    total++;
    if (bz1 !== 1'b1) $display("FAIL sim_cnt2 got %b want 1", bz1);
    else pass_cnt++;
    tick();
    idle(); a1 = 4; kv = 1; krd = 4; we_wb = 1; rd_wb = 4; tick();
    idle(); a1 = 4; #1;
    total++;
    if (udf !== 1'b1 || bz1 !== 1'b0) $display("FAIL sim_kill udf %b busy %b want 1 0", udf, bz1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(6); issue(6);
    idle(); we_wb = 1; rd_wb = 6; fin = 32'h66; tick();
    idle(); reset = 0; we_wb = 1; rd_wb = 6; fin = 32'h77; tick();
    idle(); a1 = 6; a2 = 4; u1 = 1; u2 = 1; #1;
    total++;
    if (d1 !== 32'd0 || bz1 !== 1'b0 || stall !== 1'b0) $display("FAIL rst_mid got %h busy %b stall %b want 0", d1, bz1, stall);
    else pass_cnt++;
    total++;
    if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL rst_mid_err got %b%b want 00", ovf, udf);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      reset = ($urandom_range(0, 59) != 0);
      we_wb = $urandom_range(0, 2) == 0;
      rd_wb = 5'($urandom_range(0, 6));
      fin = $urandom;
      a1 = 5'($urandom_range(0, 6)); a2 = 5'($urandom_range(0, 6));
      u1 = $urandom_range(0, 1) == 1; u2 = $urandom_range(0, 1) == 1;
      iwe = $urandom_range(0, 3) != 0;
      ird = 5'($urandom_range(0, 6));
      kv = $urandom_range(0, 7) == 0;
      krd = 5'($urandom_range(0, 6));
      #1;
      iv = !stall || ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (d1 !== m_data(a1) || d2 !== m_data(a2)) $display("FAIL rnd_data c=%0d got %h/%h want %h/%h", c, d1, d2, m_data(a1), m_data(a2));
      else pass_cnt++;
      total++;
      if (bz1 !== m_busy(a1) || bz2 !== m_busy(a2)) $display("FAIL rnd_busy c=%0d got %b%b want %b%b", c, bz1, bz2, m_busy(a1), m_busy(a2));
      else pass_cnt++;
      total++;
      if (stall !== m_stall()) $display("FAIL rnd_stall c=%0d got %b want %b", c, stall, m_stall());
      else pass_cnt++;
      total++;
      if (ovf !== movf || udf !== mudf) $display("FAIL rnd_err c=%0d got %b%b want %b%b", c, ovf, udf, movf, mudf);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      mcnt[r] = 0; mreg[r] = '0;
    end
    movf = 0; mudf = 0;
    idle();
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_raw_stall();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file and per-register in-flight scoreboard that terminates the writeback interface of the pipeline. It consumes the write-back stage's destination index, write enable and final result, presents two bypassed read ports to decode, and counts issued-but-unretired writes per register so decode can stall on RAW hazards the forwarding network cannot cover.

## Interface

Parameters:
- size, 32, data width of registers and write/read data.
- max_inflight, 3, maximum outstanding writes tracked per register. Counter width is clog2(max_inflight+1).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset.
- RD_WB  input  5  writeback destination register index.
- WE_WB  input  1  writeback write enable.
- Final_Result  input  size  writeback data.
- RS1_addr_i, RS2_addr_i  input  5 each  decode read indices.
- rs1_used_i, rs2_used_i  input  1 each  decode actually consumes that operand.
- RS1_data_o, RS2_data_o  output  size each  read data, bypassed.
- RS1_busy_o, RS2_busy_o  output  1 each  operand has an unresolved pending write.
- issue_valid_i  input  1  an instruction leaves decode this cycle.
- issue_we_i  input  1  that instruction writes a register.
- issue_rd_i  input  5  its destination.
- kill_valid_i  input  1  one previously issued writing instruction is squashed this cycle.
- kill_rd_i  input  5  destination of the squashed instruction.
- stall_o  output  1  decode must hold.
- overflow_err_o  output  1  sticky: issue attempted on a saturated counter.
- underflow_err_o  output  1  sticky: retire or kill on a zero counter.

## Operation

- Storage: 31 writable registers, x1..x31. x0 reads 0, ignores writes, is never busy, and has no counter.
- Write: on a rising edge with WE_WB=1 and RD_WB!=0, reg[RD_WB] <= Final_Result.
- Read: RSx_data_o = 0 if RSx_addr_i==0. Otherwise it is Final_Result if WE_WB and RD_WB==RSx_addr_i; otherwise it is reg[RSx_addr_i].
- Counters cnt[r] for r=1..31. Per edge the change is net: cnt[r] += inc − ret − kil.
  - inc = issue_valid_i & issue_we_i & issue_rd_i==r.
  - ret = WE_WB & RD_WB==r.
  - kil = kill_valid_i & kill_rd_i==r.
- Retire and kill may target the same register in the same cycle. Both decrements then apply.
- Saturation:
  - If the net result is above max_inflight, cnt holds max_inflight and overflow_err_o sets.
  - If the net result is below 0, cnt holds 0 and underflow_err_o sets.
  - Both error flags are sticky until reset.
- Busy: RSx_busy_o = (RSx_addr_i!=0) & (cnt[RSx_addr_i] − retx != 0).
  - retx = WE_WB & RD_WB==RSx_addr_i.
  - A write retiring in the same cycle therefore clears busy, because the bypass supplies the data.
- stall_o = (RS1_busy_o & rs1_used_i) | (RS2_busy_o & rs2_used_i) | (issue_we_i & issue_rd_i!=0 & cnt[issue_rd_i]==max_inflight & no retire/kill to issue_rd_i this cycle).
  - The issue_valid_i condition is deliberately omitted so that stall_o never depends on its own consequence.
- Decode must not assert issue_valid_i while stall_o=1. If it does, the counter update still applies, with saturation and error flags.
- Reset (reset=0 at an edge):
  - All registers, all counters and both error flags clear.
  - Reset dominates any write, issue or kill in that cycle.
  - Reset in the middle of a pipeline loses all pending counts. The pipeline is reset together with this block.

## Timing

- Reads, busy and stall are combinational from the current inputs and state: zero latency.
- A write becomes visible through the array one cycle after it is presented. It is visible through the bypass in the same cycle.
- Counter and error updates take effect at the next rising edge.
- Outputs after reset:
  - RSx_data_o = 0 for all addresses.
  - RSx_busy_o = 0, stall_o = 0.
  - overflow_err_o = 0, underflow_err_o = 0.
- No combinational path exists from issue_valid_i to any output.

## Test plan

- Reset, then write x5=0xDEADBEEF; on the following cycle read RS1_addr_i=5 → RS1_data_o=0xDEADBEEF. Write x0=0x1234 and read x0 → 0, busy=0.
- Same-cycle bypass: with WE_WB=1, RD_WB=7, Final_Result=0xA5A5A5A5, read RS2_addr_i=7 in that cycle → RS2_data_o=0xA5A5A5A5 before the edge.
- RAW stall:
  - Issue rd=3, then read RS1=3 with rs1_used_i=1 → stall_o=1 on the next cycle and every cycle until WB of x3.
  - In the WB cycle, busy=0 and data equals Final_Result.
  - With rs1_used_i=0 → stall_o=0.
- Saturation: issue rd=9 three times with no WB → cnt=3. Presenting issue_we_i=1 with rd=9 → stall_o=1. Forcing issue anyway → overflow_err_o=1, cnt stays 3. Three WBs to x9 → busy=0.
- Simultaneous events:
  - With cnt[4]=2, issue rd=4 plus WB x4 in the same cycle → cnt stays 2.
  - With cnt[4]=1, a kill and a WB of x4 in the same cycle → cnt=0 and underflow_err_o=1.
- Reset mid-operation: with cnt[6]=2 and x6 nonzero, assert reset=0 for one edge → all busy=0, reads=0, errors=0. A WB to x6 in the reset cycle is discarded.
